ring_rr_arbiter: RTL and testbench
==================================

Name: ring_rr_arbiter

Overview:
Round-robin arbiter that shares one downstream resource among N requesters.
- Priority is a one-hot rotating token held in an N-bit ring register (ring-counter style). The token advances only when a grant is released.
- Each grant lasts while its requester holds req, capped at MAX_HOLD cycles.
- Sits between N request sources and the shared datapath; grant is registered.

Parameters:
N, 4, number of requesters (N >= 1)
MAX_HOLD, 8, maximum consecutive cycles one grant may last (MAX_HOLD >= 1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req_i  input  N  request vector; bit i = requester i wants the resource
gnt_o  output  N  registered one-hot grant; all-zero when idle
gnt_valid_o  output  1  OR of gnt_o (registered)
gnt_idx_o  output  clog2(N) (min 1)  binary index of the granted requester; 0 when idle
ptr_o  output  N  one-hot priority token; this requester wins ties

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous, active-high, on reset.
- Reset values:
  - gnt_o=0, gnt_valid_o=0, gnt_idx_o=0
  - ptr_o=1 (bit 0)
  - state=IDLE, hold_cnt=0
  - Reset asserted mid-grant clears everything immediately, without waiting for a clock edge.
- Winner search: start at the bit set in ptr_o and scan upward with wrap (bit N-1 -> bit 0). The first set bit of req_i wins. The search is combinational over the current ptr and req_i.
- State IDLE:
  - If req_i != 0 at edge k: after edge k, gnt_o = winner one-hot, hold_cnt=1, state=GRANT.
  - The latency from req to gnt is one edge.
  - ptr is unchanged in IDLE.
- State GRANT (owner o):
  - Keep condition: req_i[o]=1 and hold_cnt < MAX_HOLD. The grant holds and hold_cnt increments.
  - Release condition: req_i[o]=0, or hold_cnt == MAX_HOLD.
- On release at edge k:
  - ptr_o becomes gnt_o rotated left by 1 (bit N-1 wraps to bit 0).
  - Re-arbitrate in the same edge using the rotated pointer and current req_i. There is no bubble cycle.
  - If a winner exists: gnt_o = new winner, hold_cnt=1, stay in GRANT.
  - If no winner: gnt_o=0, hold_cnt=0, go to IDLE.
- Timeout with sole requester: if the owner reaches MAX_HOLD with req still high and no other request is pending, the search wraps back to it. It is re-granted with hold_cnt=1. gnt_o stays asserted, but ptr still rotates.
- Non-owner requests during GRANT are ignored until release.
- gnt_o is always zero or one-hot. gnt_idx_o and gnt_valid_o are derived from the same registered state.
- N=1: ptr_o is constantly 1. Grant follows req, with re-grant at each MAX_HOLD boundary.
- hold_cnt width is clog2(MAX_HOLD+1). It never exceeds MAX_HOLD.

Decomposition:
- Shared constants in ring_arb_defs.vh:
  - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1
  - a clog2 function
  - default N and MAX_HOLD values
- Sub-module ring_token_reg: N-bit one-hot ring register with an advance enable and a load input.
  - Reset value is 1.
  - Rotates left with wrap when advance=1.
  - Loads (gnt_o rotated left) on release.
- The arbiter top holds the FSM, hold counter and winner search.

Test Plan:
1. Reset (N=4, MAX_HOLD=4): assert reset between edges -> gnt_o=0000, gnt_valid_o=0, gnt_idx_o=0, ptr_o=0001 immediately, before any clock edge.
2. Single hold: req_i=0001 for 3 edges, then 0000 -> gnt_o=0001 for 3 cycles starting one edge after req; then gnt_o=0000, ptr_o=0010, state IDLE.
3. All request: req_i=1111 constant -> gnt_o sequence 0001,0010,0100,1000,0001 with each grant exactly 4 cycles and no idle gap; gnt_idx_o 0,1,2,3,0; ptr_o advances at each change.
4. Pointer priority: with ptr_o=0010, apply req_i=1001 -> gnt_o=1000; on its release, ptr_o wraps to 0001 and gnt_o=0001 at that same edge.
5. Sole-requester timeout: req_i=0100 held 10 cycles -> gnt_o=0100 continuous; re-grant at cycles 4 and 8; ptr_o becomes 1000 after the first timeout.
6. Reset mid-grant: during grant to 0100 with hold_cnt=2, pulse reset -> outputs clear asynchronously; after release, req_i=0100 is granted one edge later with hold_cnt=1.

Source files
------------

// File: rtl/ring_rr_arbiter_pkg.sv
// Shared definitions for the ring round-robin arbiter.
//   - arb_state_e : FSM encodings (idle / grant held)
//   - clog2       : ceiling log2 used to size index and hold-counter fields
//   - DEFAULT_N, DEFAULT_MAX_HOLD : default parameter values
package ring_rr_arbiter_pkg;

  localparam int DEFAULT_N        = 4;
  localparam int DEFAULT_MAX_HOLD = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ring_rr_arbiter_token_reg.sv
// One-hot priority token held in an N-bit ring register.
//   clk, reset   : clock, asynchronous active-high reset (token returns to bit 0)
//   advance_i    : rotate the held token left by one position with wrap
//   load_i       : load load_val_i rotated left by one (takes priority over advance_i)
//   load_val_i   : one-hot value to be rotated and loaded (the outgoing grant)
//   load_rot_o   : load_val_i rotated left, available combinationally so the
//                  caller can search with the pointer it is about to load
//   ptr_o        : current one-hot token
module ring_token_reg #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         advance_i,
  input  logic         load_i,
  input  logic [N-1:0] load_val_i,
  output logic [N-1:0] load_rot_o,
  output logic [N-1:0] ptr_o
);

  logic [N-1:0] ptr_q;
  logic [N-1:0] ptr_d;

  // Modulo indexing keeps the rotation legal for N == 1, where it is identity.
  function automatic logic [N-1:0] rotl1(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[(i + 1) % N] = v[i];
    end
    return r;
  endfunction

  assign load_rot_o = rotl1(load_val_i);

  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_rot_o;
    end else if (advance_i) begin
      ptr_d = rotl1(ptr_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= N'(1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter sharing one downstream resource among N requesters.
// A one-hot token sets search priority; the token moves only when a grant is
// released, and the next owner is chosen on that same edge (no idle bubble).
// A grant lasts while its owner keeps req high, capped at MAX_HOLD cycles.
//   clk         : rising-edge clock
//   reset       : asynchronous active-high reset
//   req_i       : request vector, bit i = requester i wants the resource
//   gnt_o       : registered one-hot grant, zero when idle
//   gnt_valid_o : OR of gnt_o
//   gnt_idx_o   : binary index of the granted requester, 0 when idle
//   ptr_o       : one-hot priority token; this requester wins ties
module ring_rr_arbiter
  import ring_rr_arbiter_pkg::*;
#(
  parameter int  N        = DEFAULT_N,
  parameter int  MAX_HOLD = DEFAULT_MAX_HOLD,
  localparam int IDX_W    = (clog2(N) < 1) ? 1 : clog2(N),
  localparam int HOLD_W   = (clog2(MAX_HOLD + 1) < 1) ? 1 : clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     gnt_o,
  output logic             gnt_valid_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic [N-1:0]     ptr_o
);

  arb_state_e        state_q,    state_d;
  logic [N-1:0]      gnt_q,      gnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [N-1:0] ptr;
  logic [N-1:0] ptr_rot;
  logic [N-1:0] search_ptr;
  logic [N-1:0] winner;
  logic         ptr_load;
  logic         keep;

  // First set bit of req at or above the token position, wrapping at N-1.
  function automatic logic [N-1:0] find_winner(input logic [N-1:0] req,
                                               input logic [N-1:0] tok);
    logic [N-1:0] win;
    logic         found;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (tok[i]) begin
        for (int k = 0; k < N; k++) begin
          if (!found && req[(i + k) % N]) begin
            win[(i + k) % N] = 1'b1;
            found            = 1'b1;
          end
        end
      end
    end
    return win;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // The token only ever jumps to (released grant rotated left), so the
  // ring's plain advance path is unused here.
  ring_token_reg #(
    .N (N)
  ) u_token (
    .clk        (clk),
    .reset      (reset),
    .advance_i  (1'b0),
    .load_i     (ptr_load),
    .load_val_i (gnt_q),
    .load_rot_o (ptr_rot),
    .ptr_o      (ptr)
  );

  // While a grant is held the next search must use the post-release token,
  // so re-arbitration happens on the release edge itself.
  assign search_ptr = (state_q == ST_GRANT) ? ptr_rot : ptr;
  assign winner     = find_winner(req_i, search_ptr);
  assign keep       = (|(req_i & gnt_q)) && (hold_cnt_q < HOLD_W'(MAX_HOLD));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    hold_cnt_d = hold_cnt_q;
    ptr_load   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          gnt_d      = winner;
          hold_cnt_d = HOLD_W'(1);
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (keep) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end else begin
          // A sole requester that timed out is found again by the wrapped
          // search, so its grant continues while the token still moves on.
          ptr_load = 1'b1;
          if (|winner) begin
            gnt_d      = winner;
            hold_cnt_d = HOLD_W'(1);
          end else begin
            gnt_d      = '0;
            hold_cnt_d = '0;
            state_d    = ST_IDLE;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        gnt_d      = '0;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = |gnt_q;
  assign gnt_idx_o   = onehot_to_idx(gnt_q);
  assign ptr_o       = ptr;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed bench for ring_rr_arbiter with N=4, MAX_HOLD=4.
module tb_ring_rr_arbiter;
  import ring_rr_arbiter_pkg::*;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req_i = '0;
  logic [N-1:0] gnt_o;
  logic         gnt_valid_o;
  logic [1:0]   gnt_idx_o;
  logic [N-1:0] ptr_o;

  int n_checks = 0;
  int n_errors = 0;

  ring_rr_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .gnt_valid_o (gnt_valid_o),
    .gnt_idx_o   (gnt_idx_o),
    .ptr_o       (ptr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int g, input int idx, input int p);
    check({tag, " gnt"},   32'(gnt_o),       g);
    check({tag, " valid"}, 32'(gnt_valid_o), (g != 0) ? 1 : 0);
    check({tag, " idx"},   32'(gnt_idx_o),   idx);
    check({tag, " ptr"},   32'(ptr_o),       p);
  endtask

  task automatic check_state(input string tag, input int hold, input int st);
    check({tag, " hold"},  32'(dut.hold_cnt_q), hold);
    check({tag, " state"}, 32'(dut.state_q),    st);
  endtask

  // Reset pulse placed between clock edges.
  task automatic pulse_reset();
    req_i = '0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset asserted before any clock edge: outputs clear at once.
    #2;
    reset = 1'b1;
    #1;
    check_outs("reset_async", 0, 0, 1);
    check_state("reset_async", 0, 32'(ST_IDLE));
    step();
    step();
    reset = 1'b0;
    check_outs("reset_hold", 0, 0, 1);

    // Single requester holds for three edges, then drops.
    req_i = 4'b0001;
    for (int c = 1; c <= 3; c++) begin
      step();
      check_outs($sformatf("single c%0d", c), 1, 0, 1);
      check("single hold", 32'(dut.hold_cnt_q), c);
    end
    req_i = 4'b0000;
    step();
    check_outs("single rel", 0, 0, 2);
    check_state("single rel", 0, 32'(ST_IDLE));

    // All requesting: each grant lasts MAX_HOLD cycles, no idle gap.
    pulse_reset();
    req_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < MAX_HOLD; c++) begin
        step();
        check($sformatf("all g%0d c%0d gnt", g, c), 32'(gnt_o), 1 << (g % 4));
        check($sformatf("all g%0d c%0d hold", g, c), 32'(dut.hold_cnt_q), c + 1);
        if (c == 0) begin
          check($sformatf("all g%0d idx", g), 32'(gnt_idx_o), g % 4);
          check($sformatf("all g%0d ptr", g), 32'(ptr_o), 1 << (g % 4));
        end
      end
    end

    // Pointer at bit 1, requests at bits 3 and 0: bit 3 wins, then wrap to 0.
    pulse_reset();
    req_i = 4'b0001;
    step();
    req_i = 4'b0000;
    step();
    check_outs("prio setup", 0, 0, 2);
    req_i = 4'b1001;
    step();
    check_outs("prio win", 8, 3, 2);
    step();
    check_outs("prio ignore", 8, 3, 2);
    check("prio ignore hold", 32'(dut.hold_cnt_q), 2);
    req_i = 4'b0001;
    step();
    check_outs("prio wrap", 1, 0, 1);
    check_state("prio wrap", 1, 32'(ST_GRANT));

    // Sole requester past MAX_HOLD: grant continuous, counter restarts, token moves.
    pulse_reset();
    req_i = 4'b0100;
    for (int k = 1; k <= 10; k++) begin
      step();
      check_outs($sformatf("sole k%0d", k), 4, 2, (k <= MAX_HOLD) ? 1 : 8);
      check($sformatf("sole k%0d hold", k), 32'(dut.hold_cnt_q), ((k - 1) % MAX_HOLD) + 1);
    end

    // Reset in the middle of a grant clears without a clock edge.
    pulse_reset();
    req_i = 4'b0100;
    step();
    step();
    check("mid pre hold", 32'(dut.hold_cnt_q), 2);
    #2;
    reset = 1'b1;
    #1;
    check_outs("mid reset", 0, 0, 1);
    check_state("mid reset", 0, 32'(ST_IDLE));
    reset = 1'b0;
    step();
    check_outs("mid regrant", 4, 2, 1);
    check_state("mid regrant", 1, 32'(ST_GRANT));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
